// File: rtl/fpnew_divsqrt_arbiter.sv
// Round-robin arbiter that shares one iterative FP div/sqrt unit between NumReq requesters.
// A small in-order owner-ID FIFO routes each returning result back to the requester that issued it.
module fpnew_divsqrt_arbiter #(
  parameter int unsigned NumReq      = 2,
  parameter int unsigned Width       = 64,
  parameter int unsigned TagWidth    = 4,
  parameter int unsigned MaxInflight = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumReq-1:0]            req_valid_i,
  output logic [NumReq-1:0]            req_ready_o,
  input  logic [NumReq*2*Width-1:0]    req_operands_i,
  input  logic [NumReq*3-1:0]          req_rnd_mode_i,
  input  logic [NumReq*4-1:0]          req_op_i,
  input  logic [NumReq*3-1:0]          req_dst_fmt_i,
  input  logic [NumReq*TagWidth-1:0]   req_tag_i,
  output logic                         unit_valid_o,
  input  logic                         unit_ready_i,
  output logic [2*Width-1:0]           unit_operands_o,
  output logic [2:0]                   unit_rnd_mode_o,
  output logic [3:0]                   unit_op_o,
  output logic [2:0]                   unit_dst_fmt_o,
  output logic [TagWidth-1:0]          unit_tag_o,
  output logic                         unit_flush_o,
  input  logic                         unit_out_valid_i,
  output logic                         unit_out_ready_o,
  input  logic [Width-1:0]             unit_result_i,
  input  logic [4:0]                   unit_status_i,
  input  logic [TagWidth-1:0]          unit_tag_i,
  output logic [NumReq-1:0]            rsp_valid_o,
  input  logic [NumReq-1:0]            rsp_ready_i,
  output logic [Width-1:0]             rsp_result_o,
  output logic [4:0]                   rsp_status_o,
  output logic [TagWidth-1:0]          rsp_tag_o,
  input  logic                         flush_i,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int unsigned IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PtrW = (MaxInflight > 1) ? $clog2(MaxInflight) : 1;
  localparam int unsigned CntW = $clog2(MaxInflight + 1);

  typedef logic [IdW-1:0]  id_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  // Handshakes: a transfer happens on a cycle where valid and ready are both high at the
  // rising edge; valid never depends on ready, and while valid is up without ready the
  // payload is held (the issue side enforces this with the lock).

  id_t  rr_q, rr_d;
  logic lock_q, lock_d;
  id_t  lock_id_q, lock_id_d;
  logic err_q, err_d;
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t cnt_q, cnt_d;
  id_t  fifo_q [MaxInflight];
  id_t  fifo_d [MaxInflight];

  id_t  grant;
  id_t  cand;
  logic found;
  logic full;
  logic empty;
  logic issue_hs;
  logic pop;
  id_t  head_id;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(MaxInflight - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == cnt_t'(MaxInflight));
  assign empty   = (cnt_q == '0);
  assign head_id = fifo_q[rd_ptr_q];

  // A locked grant is held for its owner; otherwise search from rr_q with wrap-around.
  always_comb begin
    grant = lock_id_q;
    found = 1'b0;
    cand  = '0;
    if (lock_q) begin
      found = req_valid_i[lock_id_q];
    end else begin
      grant = rr_q;
      for (int k = 0; k < int'(NumReq); k++) begin
        cand = id_t'((int'(rr_q) + k) % int'(NumReq));
        if (!found && req_valid_i[cand]) begin
          found = 1'b1;
          grant = cand;
        end
      end
    end
  end

  assign unit_valid_o = found & ~full & ~flush_i;
  assign issue_hs     = unit_valid_o & unit_ready_i;
  assign unit_flush_o = flush_i;

  always_comb begin
    unit_operands_o = '0;
    unit_rnd_mode_o = '0;
    unit_op_o       = '0;
    unit_dst_fmt_o  = '0;
    unit_tag_o      = '0;
    if (unit_valid_o) begin
      unit_operands_o = req_operands_i[int'(grant)*2*Width +: 2*Width];
      unit_rnd_mode_o = req_rnd_mode_i[int'(grant)*3 +: 3];
      unit_op_o       = req_op_i[int'(grant)*4 +: 4];
      unit_dst_fmt_o  = req_dst_fmt_i[int'(grant)*3 +: 3];
      unit_tag_o      = req_tag_i[int'(grant)*TagWidth +: TagWidth];
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (issue_hs) req_ready_o[grant] = 1'b1;
  end

  // Return path: only the FIFO head owner sees the result; a stray result is never acked.
  assign unit_out_ready_o = ~empty & ~flush_i & rsp_ready_i[head_id];
  assign pop              = unit_out_valid_i & unit_out_ready_o;

  always_comb begin
    rsp_valid_o = '0;
    if (unit_out_valid_i && !empty && !flush_i) rsp_valid_o[head_id] = 1'b1;
  end

  assign rsp_result_o = unit_result_i;
  assign rsp_status_o = unit_status_i;
  assign rsp_tag_o    = unit_tag_i;

  assign busy_o = ~empty | lock_q;
  assign err_o  = err_q;

  always_comb begin
    rr_d      = rr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    fifo_d    = fifo_q;
    err_d     = err_q | (unit_out_valid_i & empty);
    if (flush_i) begin
      lock_d   = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (issue_hs) begin
        fifo_d[wr_ptr_q] = grant;
        wr_ptr_d         = ptr_inc(wr_ptr_q);
        rr_d             = (grant == id_t'(NumReq - 1)) ? '0 : grant + 1'b1;
        lock_d           = 1'b0;
      end else if (unit_valid_o) begin
        lock_d    = 1'b1;
        lock_id_d = grant;
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({issue_hs, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      err_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      fifo_q    <= '{default: '0};
    end else begin
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      fifo_q    <= fifo_d;
    end
  end

  // Requester-side protocol: a locked request may not be withdrawn or change its payload.
  a_lock_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (lock_q && !flush_i) |-> req_valid_i[lock_id_q]);
  a_lock_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (lock_q && !flush_i && $past(unit_valid_o)) |-> (unit_operands_o == $past(unit_operands_o)));
  a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready_o));

endmodule

// File: tb/tb_fpnew_divsqrt_arbiter.sv
// Randomized bench for fpnew_divsqrt_arbiter: requesters and a toy div/sqrt unit are modelled
// here, and a queue-based reference predicts grants, routing, busy and error every cycle.
module tb_fpnew_divsqrt_arbiter;

  localparam int N  = 2;
  localparam int W  = 64;
  localparam int TW = 4;
  localparam int MI = 2;

  // clock / reset
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [N-1:0]        req_valid_i;
  logic [N-1:0]        req_ready_o;
  logic [N*2*W-1:0]    req_operands_i;
  logic [N*3-1:0]      req_rnd_mode_i;
  logic [N*4-1:0]      req_op_i;
  logic [N*3-1:0]      req_dst_fmt_i;
  logic [N*TW-1:0]     req_tag_i;
  logic                unit_valid_o;
  logic                unit_ready_i;
  logic [2*W-1:0]      unit_operands_o;
  logic [2:0]          unit_rnd_mode_o;
  logic [3:0]          unit_op_o;
  logic [2:0]          unit_dst_fmt_o;
  logic [TW-1:0]       unit_tag_o;
  logic                unit_flush_o;
  logic                unit_out_valid_i;
  logic                unit_out_ready_o;
  logic [W-1:0]        unit_result_i;
  logic [4:0]          unit_status_i;
  logic [TW-1:0]       unit_tag_i;
  logic [N-1:0]        rsp_valid_o;
  logic [N-1:0]        rsp_ready_i;
  logic [W-1:0]        rsp_result_o;
  logic [4:0]          rsp_status_o;
  logic [TW-1:0]       rsp_tag_o;
  logic                flush_i;
  logic                busy_o;
  logic                err_o;

  fpnew_divsqrt_arbiter #(
    .NumReq(N), .Width(W), .TagWidth(TW), .MaxInflight(MI)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_operands_i(req_operands_i), .req_rnd_mode_i(req_rnd_mode_i),
    .req_op_i(req_op_i), .req_dst_fmt_i(req_dst_fmt_i), .req_tag_i(req_tag_i),
    .unit_valid_o(unit_valid_o), .unit_ready_i(unit_ready_i),
    .unit_operands_o(unit_operands_o), .unit_rnd_mode_o(unit_rnd_mode_o),
    .unit_op_o(unit_op_o), .unit_dst_fmt_o(unit_dst_fmt_o), .unit_tag_o(unit_tag_o),
    .unit_flush_o(unit_flush_o),
    .unit_out_valid_i(unit_out_valid_i), .unit_out_ready_o(unit_out_ready_o),
    .unit_result_i(unit_result_i), .unit_status_i(unit_status_i), .unit_tag_i(unit_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_status_o(rsp_status_o), .rsp_tag_o(rsp_tag_o),
    .flush_i(flush_i), .busy_o(busy_o), .err_o(err_o)
  );

  // requester state: a request stays pending with frozen payload until accepted
  bit             pend  [N];
  logic [2*W-1:0] r_ops [N];
  logic [2:0]     r_rnd [N];
  logic [3:0]     r_op  [N];
  logic [2:0]     r_fmt [N];
  logic [TW-1:0]  r_tag [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_valid_i[i]                = pend[i];
      req_operands_i[i*2*W +: 2*W]  = r_ops[i];
      req_rnd_mode_i[i*3 +: 3]      = r_rnd[i];
      req_op_i[i*4 +: 4]            = r_op[i];
      req_dst_fmt_i[i*3 +: 3]       = r_fmt[i];
      req_tag_i[i*TW +: TW]         = r_tag[i];
    end
  end

  // reference model state
  int            rr_m;
  int            lock_m;
  int            own_q[$];
  logic [TW-1:0] own_tag_q[$];
  bit            err_m;

  // toy unit: results in issue order, at least 3 cycles after issue
  logic [W-1:0]  u_res_q[$];
  logic [4:0]    u_st_q[$];
  int            u_cyc_q[$];
  bit            uov;
  int            cyc;

  // stimulus knobs (percent, flush in per-mille)
  int p_req, p_urdy, p_rrdy, p_uov, p_flush;
  bit force_stray;

  // per-cycle predictions shared between check and update
  int g;
  bit e_uv, e_hs, e_or, have_h;

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0h expected=%0h", tag, cyc, act, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && $urandom_range(99) < p_req) begin
        pend[i]  = 1'b1;
        r_ops[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        r_rnd[i] = 3'($urandom_range(7));
        r_op[i]  = 4'($urandom_range(15));
        r_fmt[i] = 3'($urandom_range(7));
        r_tag[i] = TW'($urandom());
      end
      rsp_ready_i[i] = ($urandom_range(99) < p_rrdy);
    end
    unit_ready_i = ($urandom_range(99) < p_urdy);
    flush_i      = ($urandom_range(999) < p_flush);
    if (!uov && u_res_q.size() > 0 && (cyc - u_cyc_q[0]) >= 3 && $urandom_range(99) < p_uov)
      uov = 1'b1;
    if (uov) begin
      unit_out_valid_i = 1'b1;
      unit_result_i    = u_res_q[0];
      unit_status_i    = u_st_q[0];
      unit_tag_i       = own_tag_q[0];
    end else begin
      unit_out_valid_i = force_stray;
      unit_result_i    = {$urandom(), $urandom()};
      unit_status_i    = 5'($urandom());
      unit_tag_i       = TW'($urandom());
    end
  endtask

  task automatic check_cycle();
    logic [N-1:0] e_rv;
    int h;
    g = -1;
    if (lock_m >= 0) begin
      if (pend[lock_m]) g = lock_m;
    end else begin
      for (int k = 0; k < N; k++)
        if (g < 0 && pend[(rr_m + k) % N]) g = (rr_m + k) % N;
    end
    e_uv   = (g >= 0) && (own_q.size() < MI) && !flush_i;
    e_hs   = e_uv && unit_ready_i;
    have_h = own_q.size() > 0;
    h      = have_h ? own_q[0] : 0;
    e_or   = have_h && !flush_i && rsp_ready_i[h];
    e_rv   = (unit_out_valid_i && have_h && !flush_i) ? N'(1 << h) : '0;

    check_eq("unit_valid", 128'(unit_valid_o), 128'(e_uv));
    check_eq("req_ready", 128'(req_ready_o), e_hs ? 128'(1 << g) : 128'(0));
    if (e_uv) begin
      check_eq("unit_operands", unit_operands_o, r_ops[g]);
      check_eq("unit_ctrl", 128'({unit_rnd_mode_o, unit_op_o, unit_dst_fmt_o}),
               128'({r_rnd[g], r_op[g], r_fmt[g]}));
      check_eq("unit_tag", 128'(unit_tag_o), 128'(r_tag[g]));
    end
    check_eq("rsp_valid", 128'(rsp_valid_o), 128'(e_rv));
    check_eq("unit_out_ready", 128'(unit_out_ready_o), 128'(e_or));
    if (e_rv != '0) begin
      check_eq("rsp_tag", 128'(rsp_tag_o), 128'(own_tag_q[0]));
      check_eq("rsp_result", 128'(rsp_result_o), 128'(u_res_q[0]));
      check_eq("rsp_status", 128'(rsp_status_o), 128'(u_st_q[0]));
    end
    check_eq("busy", 128'(busy_o), 128'(have_h || lock_m >= 0));
    check_eq("err", 128'(err_o), 128'(err_m));
    check_eq("unit_flush", 128'(unit_flush_o), 128'(flush_i));
  endtask

  task automatic update();
    if (unit_out_valid_i && !have_h) err_m = 1'b1;
    if (flush_i) begin
      own_q.delete();
      own_tag_q.delete();
      u_res_q.delete();
      u_st_q.delete();
      u_cyc_q.delete();
      uov    = 1'b0;
      lock_m = -1;
    end else begin
      if (unit_out_valid_i && e_or) begin
        void'(own_q.pop_front());
        void'(own_tag_q.pop_front());
        void'(u_res_q.pop_front());
        void'(u_st_q.pop_front());
        void'(u_cyc_q.pop_front());
        uov = 1'b0;
      end
      if (e_hs) begin
        own_q.push_back(g);
        own_tag_q.push_back(r_tag[g]);
        u_res_q.push_back(r_ops[g][W-1:0] ^ r_ops[g][2*W-1:W]);
        u_st_q.push_back(5'($urandom()));
        u_cyc_q.push_back(cyc);
        pend[g] = 1'b0;
        rr_m    = (g + 1) % N;
        lock_m  = -1;
      end else if (e_uv) begin
        lock_m = g;
      end
    end
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk_i);
      drive();
      #1;
      check_cycle();
      @(posedge clk_i);
      #1;
      update();
      cyc++;
    end
  endtask

  initial begin
    rr_m = 0; lock_m = -1; err_m = 1'b0; uov = 1'b0; cyc = 0; force_stray = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; r_ops[i] = '0; r_rnd[i] = '0; r_op[i] = '0; r_fmt[i] = '0; r_tag[i] = '0;
    end
    unit_ready_i = 1'b0; unit_out_valid_i = 1'b0; unit_result_i = '0; unit_status_i = '0;
    unit_tag_i = '0; rsp_ready_i = '0; flush_i = 1'b0;

    // reset state
    repeat (3) @(negedge clk_i);
    check_eq("rst_unit_valid", 128'(unit_valid_o), 128'(0));
    check_eq("rst_req_ready", 128'(req_ready_o), 128'(0));
    check_eq("rst_rsp_valid", 128'(rsp_valid_o), 128'(0));
    check_eq("rst_unit_out_ready", 128'(unit_out_ready_o), 128'(0));
    check_eq("rst_unit_operands", unit_operands_o, 128'(0));
    check_eq("rst_busy", 128'(busy_o), 128'(0));
    check_eq("rst_err", 128'(err_o), 128'(0));
    rst_ni = 1'b1;

    // idle after reset
    p_req = 0; p_urdy = 0; p_rrdy = 0; p_uov = 0; p_flush = 0;
    run_cycles(5);
    // both requesters always asking, unit always ready, results as soon as allowed
    p_req = 100; p_urdy = 100; p_rrdy = 100; p_uov = 100; p_flush = 0;
    run_cycles(300);
    // unit issue stalls force locks
    p_req = 100; p_urdy = 25; p_rrdy = 100; p_uov = 80;
    run_cycles(300);
    // response backpressure keeps the owner FIFO full
    p_req = 90; p_urdy = 90; p_rrdy = 30; p_uov = 70;
    run_cycles(300);
    // mixed traffic with occasional flushes
    p_req = 60; p_urdy = 70; p_rrdy = 60; p_uov = 60; p_flush = 25;
    run_cycles(600);

    // flush everything, then a stray result must set the sticky error
    p_req = 0; p_urdy = 0; p_uov = 0; p_flush = 1000;
    run_cycles(1);
    p_flush = 0;
    run_cycles(3);
    force_stray = 1'b1;
    run_cycles(1);
    force_stray = 1'b0;
    run_cycles(4);
    check_eq("err_sticky", 128'(err_o), 128'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
